// File: rtl/alu_writeback_sequencer.sv
// Sequences one relay-ALU operation: hold function code, wait for settle, write A/D and flags.
// Optional macro RELAY_SETTLE_EN adds the SETTLE state and its counter; undefined -> IDLE goes straight to WRITE.
module alu_writeback_sequencer #(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_start,
    input  logic [2:0] fctn_code_in,
    input  logic       dest_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_sign,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic [2:0] alu_fctn_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_a,
    output logic [7:0] reg_d,
    output logic       flag_sign,
    output logic       flag_carry,
    output logic       flag_zero,
    output logic [1:0] state_dbg
);

    // Handshake: alu_start is taken only when busy=0 (IDLE); a start seen while busy is
    // dropped, and done pulses for exactly one cycle once registers and flags hold the result.

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || SETTLE_CYCLES >= (1 << CNT_W)) begin : g_param_check
        $error("SETTLE_CYCLES must be 1..15 and fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   dest_q;

`ifdef RELAY_SETTLE_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_IDLE && alu_start) begin
            cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (state == S_SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (alu_start) begin
`ifdef RELAY_SETTLE_EN
                    state_nx = S_SETTLE;
`else
                    state_nx = S_WRITE;
`endif
                end
            end
            S_SETTLE: begin
`ifdef RELAY_SETTLE_EN
                if (cnt == '0) state_nx = S_WRITE;
`else
                state_nx = S_IDLE;
`endif
            end
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            alu_fctn_out <= 3'b111;
            dest_q       <= 1'b0;
            reg_a        <= 8'h00;
            reg_d        <= 8'h00;
            flag_sign    <= 1'b0;
            flag_carry   <= 1'b0;
            flag_zero    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && alu_start) begin
                alu_fctn_out <= fctn_code_in;
                dest_q       <= dest_sel;
            end else if (state == S_DONE) begin
                alu_fctn_out <= 3'b111;
            end
            if (state == S_WRITE) begin
                if (dest_q) reg_d <= alu_result;
                else        reg_a <= alu_result;
                flag_sign  <= alu_sign;
                flag_zero  <= alu_zero;
                // Only the adder ops (ADD, INC) produce a meaningful carry.
                flag_carry <= (alu_fctn_out == 3'd0 || alu_fctn_out == 3'd1) ? alu_carry : 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Scoreboard bench for alu_writeback_sequencer: directed ops push expectations, a monitor checks each done.
module tb_alu_writeback_sequencer;

    localparam int SETTLE = 3;
`ifdef RELAY_SETTLE_EN
    localparam int EXP_BUSY = SETTLE + 2;
`else
    localparam int EXP_BUSY = 2;
`endif
    localparam int W = 22;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_start = 1'b0;
    logic [2:0] fctn_code_in = 3'd0;
    logic       dest_sel = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_sign = 1'b0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic [2:0] alu_fctn_out;
    logic       busy, done;
    logic [7:0] reg_a, reg_d;
    logic       flag_sign, flag_carry, flag_zero;
    logic [1:0] state_dbg;

    alu_writeback_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .alu_start(alu_start), .fctn_code_in(fctn_code_in),
        .dest_sel(dest_sel), .alu_result(alu_result), .alu_sign(alu_sign),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_fctn_out(alu_fctn_out),
        .busy(busy), .done(done), .reg_a(reg_a), .reg_d(reg_d), .flag_sign(flag_sign),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // entry = {code[21:19], reg_a[18:11], reg_d[10:3], S, C, Z}
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic       mon_en = 1'b0;
    logic [7:0] model_a = 8'h00;
    logic [7:0] model_d = 8'h00;
    logic       model_s = 1'b0, model_c = 1'b0, model_z = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                busy_cnt++;
                if (exp_q.size() == 0) begin
                    check("busy_without_op", {31'd0, busy}, 32'd0);
                end else begin
                    check("fctn_hold", {29'd0, alu_fctn_out}, {29'd0, exp_q[0][21:19]});
                    if (done) begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        check("reg_a", {24'd0, reg_a}, {24'd0, e[18:11]});
                        check("reg_d", {24'd0, reg_d}, {24'd0, e[10:3]});
                        check("flags_scz", {29'd0, flag_sign, flag_carry, flag_zero}, {29'd0, e[2:0]});
                        check("latency", busy_cnt, EXP_BUSY);
                    end
                end
            end else begin
                busy_cnt = 0;
                check("idle_fctn", {29'd0, alu_fctn_out}, 32'd7);
                check("idle_done", {31'd0, done}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] code, input logic dst, input logic [7:0] res,
                         input logic s, input logic c, input logic z, input logic poke);
        int n;
        @(negedge clk);
        fctn_code_in = code; dest_sel = dst;
        alu_result = res; alu_sign = s; alu_carry = c; alu_zero = z;
        alu_start = 1'b1;
        if (dst) model_d = res; else model_a = res;
        model_s = s; model_z = z;
        model_c = (code == 3'd0 || code == 3'd1) ? c : 1'b0;
        exp_q.push_back({code, model_a, model_d, model_s, model_c, model_z});
        @(negedge clk);
        if (poke) begin
            // a second request while busy must be ignored, as must changed inputs
            fctn_code_in = ~code; dest_sel = ~dst;
        end else begin
            alu_start = 1'b0;
        end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            alu_start = 1'b0;
            n++;
        end
        alu_start = 1'b0;
        check("op_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset for two cycles
        repeat (2) @(negedge clk);
        check("rst_reg_a", {24'd0, reg_a}, 32'd0);
        check("rst_reg_d", {24'd0, reg_d}, 32'd0);
        check("rst_flags", {29'd0, flag_sign, flag_carry, flag_zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fctn", {29'd0, alu_fctn_out}, 32'd7);
        rst_n = 1'b1;
        mon_en = 1'b1;

        //      code  dst   result  S     C     Z     poke
        do_op(3'd0, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b0, 1'b0); // ADD -> A, carry kept
        do_op(3'd4, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0); // XOR -> D, carry forced 0
        do_op(3'd1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0); // INC -> A, sign
        do_op(3'd2, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0); // AND -> D
        do_op(3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); // CLR -> A
        do_op(3'd6, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1); // SHL -> D, start while busy
        do_op(3'd1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0); // INC -> D, carry out wraps
        do_op(3'd3, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0); // OR -> A, back-to-back
        repeat (3) @(negedge clk);

        // reset mid-op: accepted op is aborted, no write, no done
        fctn_code_in = 3'd0; dest_sel = 1'b0; alu_result = 8'h77;
        alu_sign = 1'b0; alu_carry = 1'b1; alu_zero = 1'b0;
        alu_start = 1'b1;
        exp_q.push_back({3'd0, 8'h77, model_d, 3'b010});
        @(negedge clk);
        alu_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_a = 8'h00; model_d = 8'h00; model_s = 1'b0; model_c = 1'b0; model_z = 1'b0;
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_reg_a", {24'd0, reg_a}, 32'd0);
        check("abort_reg_d", {24'd0, reg_d}, 32'd0);
        check("abort_flags", {29'd0, flag_sign, flag_carry, flag_zero}, 32'd0);
        repeat (8) @(negedge clk);

        do_op(3'd5, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0); // NOT -> D after abort
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
